// File: rtl/fft8_frame_loader.sv
// fft8_frame_loader
//
// Framing stage in front of the 8-point radix-2 DIF FFT core. Incoming
// samples are double-buffered into 8-sample frames. Each full frame is
// replayed as a 10-cycle valid burst: 8 samples followed by 2 zero cycles
// that give the core time to compute. After the last real frame, one
// all-zero flush burst is appended so that the core emits the final
// spectrum. bin_valid/bin_idx mark which cycles of the core's serial
// output carry real bins of the previous real frame.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active high
//   s_data       input sample
//   s_valid      input sample present
//   s_ready      loader can accept a sample (combinational)
//   fft_valid    drives the core's valid input (registered)
//   fft_data     drives the core's data_in input (registered)
//   frame_start  high in phase 0 of every burst (registered)
//   bin_valid    core output is a real bin of the previous frame (registered)
//   bin_idx      bin number of the core output, 0 when bin_valid is low
module fft8_frame_loader #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              fft_valid,
  output logic [DATA_W-1:0] fft_data,
  output logic              frame_start,
  output logic              bin_valid,
  output logic [2:0]        bin_idx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [3:0] LAST_SAMPLE = 4'd7;
  localparam logic [3:0] LAST_PHASE  = 4'd9;

  logic [DATA_W-1:0] bank [2][8];
  logic [1:0]        full, full_next;
  logic              wr_bank;
  logic [2:0]        wr_idx;
  logic              wr_fire;
  logic              rd_bank, rd_bank_next;
  state_t            state, state_next;
  logic [3:0]        phase, phase_next;
  logic              prev_real, prev_real_next;

  // Next values of the registered outputs, derived from the next state so
  // that the outputs line up with the state and phase they describe.
  logic              valid_next;
  logic [DATA_W-1:0] data_next;
  logic              start_next;
  logic              bin_valid_next;
  logic [2:0]        bin_idx_next;

  // Held low during reset so nothing is accepted while the buffers clear.
  assign s_ready = !full[wr_bank] && !rst;
  assign wr_fire = s_valid && s_ready;

  // NOTE: every signal written here gets a default first; a path that
  // skips an assignment would otherwise infer a latch.
  always_comb begin
    state_next     = state;
    phase_next     = phase;
    rd_bank_next   = rd_bank;
    prev_real_next = prev_real;
    full_next      = full;

    // The write side only ever completes a bank that is not full, and the
    // read side only releases a full one, so these never hit the same bit.
    if (wr_fire && wr_idx == 3'd7) begin
      full_next[wr_bank] = 1'b1;
    end

    case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          state_next = SEND;
          phase_next = '0;
        end
      end
      SEND: begin
        phase_next = phase + 4'd1;
        if (phase == LAST_SAMPLE) begin
          full_next[rd_bank] = 1'b0;
          rd_bank_next       = !rd_bank;
        end
        if (phase == LAST_PHASE) begin
          phase_next     = '0;
          prev_real_next = 1'b1;
          // rd_bank already points at the other bank since phase 7.
          state_next     = full[rd_bank] ? SEND : FLUSH;
        end
      end
      FLUSH: begin
        phase_next = phase + 4'd1;
        // A frame that completes mid-flush waits here; the flush always
        // runs its full 10 cycles so the core counter stays aligned.
        if (phase == LAST_PHASE) begin
          phase_next     = '0;
          prev_real_next = 1'b0;
          state_next     = full[rd_bank] ? SEND : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        phase_next = '0;
      end
    endcase

    valid_next = (state_next != IDLE);
    data_next  = '0;
    // rd_bank only changes on the 7->8 step, where the data is zero anyway.
    if (state_next == SEND && phase_next <= LAST_SAMPLE) begin
      data_next = bank[rd_bank][phase_next[2:0]];
    end
    start_next     = valid_next && (phase_next == 4'd0);
    bin_valid_next = valid_next && (phase_next <= LAST_SAMPLE) && prev_real_next;
    bin_idx_next   = bin_valid_next ? phase_next[2:0] : 3'd0;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      phase       <= '0;
      rd_bank     <= 1'b0;
      prev_real   <= 1'b0;
      full        <= '0;
      wr_bank     <= 1'b0;
      wr_idx      <= '0;
      fft_valid   <= 1'b0;
      fft_data    <= '0;
      frame_start <= 1'b0;
      bin_valid   <= 1'b0;
      bin_idx     <= '0;
    end else begin
      state       <= state_next;
      phase       <= phase_next;
      rd_bank     <= rd_bank_next;
      prev_real   <= prev_real_next;
      full        <= full_next;
      if (wr_fire) begin
        wr_idx <= wr_idx + 3'd1;
        if (wr_idx == 3'd7) begin
          wr_bank <= !wr_bank;
        end
      end
      fft_valid   <= valid_next;
      fft_data    <= data_next;
      frame_start <= start_next;
      bin_valid   <= bin_valid_next;
      bin_idx     <= bin_idx_next;
    end
  end

  // NOTE: the sample banks carry no reset; clearing the full flags is what
  // discards their contents, and a stale word is never read before rewrite.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      bank[wr_bank][wr_idx] <= s_data;
    end
  end

endmodule

// File: tb/tb_fft8_frame_loader.sv
// Testbench for fft8_frame_loader. Every stimulus frame pushes its samples
// to a source queue and the burst beats it should produce to a scoreboard
// queue; beats are popped and compared whenever fft_valid is high.
module tb_fft8_frame_loader;

  localparam int DATA_W = 16;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              bin_valid;
    logic [2:0]        bin_idx;
    logic              frame_start;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic              fft_valid;
  logic [DATA_W-1:0] fft_data;
  logic              frame_start;
  logic              bin_valid;
  logic [2:0]        bin_idx;

  int total = 0;
  int bad   = 0;

  int  cyc = 0;
  bit  feed_en = 1'b0;
  int  feed_from = 0;
  int  hs_cyc[$];
  logic [DATA_W-1:0] src_q[$];
  beat_t exp_q[$];

  int  v_cnt = 0;
  int  rises = 0;
  int  bin_cnt = 0;
  int  first_rise = -1;
  bit  prev_v = 1'b0;

  always #5 clk = ~clk;

  fft8_frame_loader #(.DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .fft_valid   (fft_valid),
    .fft_data    (fft_data),
    .frame_start (frame_start),
    .bin_valid   (bin_valid),
    .bin_idx     (bin_idx)
  );

  // Queue one real frame base, base+1, ... base+7 and the SEND burst it
  // produces; prev says whether the burst before it carried a real frame.
  task automatic push_frame(input logic [DATA_W-1:0] base, input bit prev);
    beat_t b;
    for (int p = 0; p < 10; p++) begin
      if (p < 8) src_q.push_back(base + DATA_W'(p));
      b.data        = (p < 8) ? base + DATA_W'(p) : '0;
      b.bin_valid   = prev && (p < 8);
      b.bin_idx     = b.bin_valid ? 3'(p) : 3'd0;
      b.frame_start = (p == 0);
      exp_q.push_back(b);
    end
  endtask

  task automatic push_flush(input bit prev);
    beat_t b;
    for (int p = 0; p < 10; p++) begin
      b.data        = '0;
      b.bin_valid   = prev && (p < 8);
      b.bin_idx     = b.bin_valid ? 3'(p) : 3'd0;
      b.frame_start = (p == 0);
      exp_q.push_back(b);
    end
  endtask

  // One clock: observe at the falling edge, score any burst beat, then
  // present the next sample for the coming rising edge.
  task automatic tick();
    beat_t obs;
    beat_t want;
    @(negedge clk);
    cyc++;
    if (fft_valid === 1'b1) begin
      obs = '{fft_data, bin_valid, bin_idx, frame_start};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL beat_extra: got data=%h bv=%b idx=%0d fs=%b, want no beat",
                 fft_data, bin_valid, bin_idx, frame_start);
      end else begin
        want = exp_q.pop_front();
        if (obs !== want) begin
          bad++;
          $display("FAIL beat: got data=%h bv=%b idx=%0d fs=%b, want data=%h bv=%b idx=%0d fs=%b",
                   obs.data, obs.bin_valid, obs.bin_idx, obs.frame_start,
                   want.data, want.bin_valid, want.bin_idx, want.frame_start);
        end
      end
      v_cnt++;
      if (!prev_v) begin
        rises++;
        if (first_rise < 0) first_rise = cyc;
      end
      if (bin_valid === 1'b1) bin_cnt++;
    end
    prev_v  = (fft_valid === 1'b1);
    s_valid = !rst && feed_en && (src_q.size() != 0) && (cyc >= feed_from);
    s_data  = s_valid ? src_q[0] : '0;
    if (s_valid && s_ready === 1'b1) begin
      void'(src_q.pop_front());
      hs_cyc.push_back(cyc);
    end
  endtask

  task automatic assert_reset();
    rst        = 1'b1;
    s_valid    = 1'b0;
    s_data     = '0;
    feed_en    = 1'b0;
    feed_from  = 0;
    src_q.delete();
    exp_q.delete();
    hs_cyc.delete();
    v_cnt      = 0;
    rises      = 0;
    bin_cnt    = 0;
    first_rise = -1;
    prev_v     = 1'b0;
  endtask

  task automatic do_reset(input int n);
    assert_reset();
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int waited = 0;
    do_reset(2);
    push_frame(16'h0A00, 1'b0);
    push_frame(16'h0B00, 1'b1);
    feed_en = 1'b1;
    while (fft_valid !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    total++;
    if (fft_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_setup: got fft_valid=%b, want 1 within 40 cycles", fft_valid);
    end
    repeat (3) tick();
    assert_reset();
    #1;
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({s_ready, fft_valid, fft_data, frame_start, bin_valid, bin_idx} !== '0) begin
        bad++;
        $display("FAIL reset_hold: got rdy=%b v=%b d=%h fs=%b bv=%b idx=%0d, want all 0",
                 s_ready, fft_valid, fft_data, frame_start, bin_valid, bin_idx);
      end
      tick();
    end
    rst = 1'b0;
    #1;
    total++;
    if (s_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: got %b, want 1", s_ready);
    end
    total++;
    if ({fft_valid, fft_data, frame_start, bin_valid, bin_idx} !== '0) begin
      bad++;
      $display("FAIL reset_release_outs: got v=%b d=%h fs=%b bv=%b idx=%0d, want all 0",
               fft_valid, fft_data, frame_start, bin_valid, bin_idx);
    end
    repeat (30) tick();
    total++;
    if (v_cnt != 0) begin
      bad++;
      $display("FAIL reset_discard: got %0d valid cycles after reset, want 0", v_cnt);
    end
  endtask

  task automatic test_single_frame();
    do_reset(2);
    push_frame(16'd1, 1'b0);
    push_flush(1'b1);
    feed_en = 1'b1;
    repeat (60) tick();
    total++;
    if (hs_cyc.size() != 8) begin
      bad++;
      $display("FAIL single_handshakes: got %0d, want 8", hs_cyc.size());
    end else begin
      total++;
      if (first_rise != hs_cyc[7] + 2) begin
        bad++;
        $display("FAIL single_latency: got rise at %0d, want %0d", first_rise, hs_cyc[7] + 2);
      end
    end
    total++;
    if (v_cnt != 20 || rises != 1) begin
      bad++;
      $display("FAIL single_burst_len: got %0d cycles in %0d runs, want 20 in 1", v_cnt, rises);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL single_missing: got %0d beats unseen, want 0", exp_q.size());
    end
    total++;
    if (fft_valid !== 1'b0 || s_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_idle: got v=%b rdy=%b, want v=0 rdy=1", fft_valid, s_ready);
    end
  endtask

  task automatic test_continuous();
    int low_a = 0;
    int low_b = 0;
    int c;
    do_reset(2);
    for (int f = 0; f < 5; f++) push_frame(DATA_W'(16'h1000 * (f + 1)), f != 0);
    push_flush(1'b1);
    feed_en = 1'b1;
    for (int k = 0; k < 120; k++) begin
      tick();
      if (hs_cyc.size() >= 8) begin
        c = hs_cyc[7];
        if (cyc >= c + 20 && cyc <= c + 29 && s_ready !== 1'b1) low_a++;
        if (cyc >= c + 30 && cyc <= c + 39 && s_ready !== 1'b1) low_b++;
      end
    end
    total++;
    if (hs_cyc.size() != 40) begin
      bad++;
      $display("FAIL cont_handshakes: got %0d, want 40", hs_cyc.size());
    end else begin
      total++;
      if (first_rise != hs_cyc[7] + 2) begin
        bad++;
        $display("FAIL cont_latency: got rise at %0d, want %0d", first_rise, hs_cyc[7] + 2);
      end
    end
    total++;
    if (v_cnt != 60 || rises != 1) begin
      bad++;
      $display("FAIL cont_valid: got %0d cycles in %0d runs, want 60 in 1", v_cnt, rises);
    end
    total++;
    if (low_a != 2 || low_b != 2) begin
      bad++;
      $display("FAIL cont_backpressure: got %0d and %0d low per 10, want 2 and 2", low_a, low_b);
    end
    total++;
    if (bin_cnt != 40) begin
      bad++;
      $display("FAIL cont_bins: got %0d bin_valid cycles, want 40", bin_cnt);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL cont_missing: got %0d beats unseen, want 0", exp_q.size());
    end
  endtask

  task automatic test_back_pressure();
    logic sr9  = 1'bx;
    logic sr10 = 1'bx;
    int   c;
    do_reset(2);
    push_frame(16'h3000, 1'b0);
    push_frame(16'h3100, 1'b1);
    push_frame(16'h3200, 1'b1);
    push_flush(1'b1);
    feed_en = 1'b1;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (hs_cyc.size() >= 8) begin
        c = hs_cyc[7];
        if (cyc == c + 9)  sr9  = s_ready;
        if (cyc == c + 10) sr10 = s_ready;
      end
    end
    total++;
    if (hs_cyc.size() != 24) begin
      bad++;
      $display("FAIL bp_handshakes: got %0d, want 24", hs_cyc.size());
    end else begin
      c = hs_cyc[7];
      total++;
      if (hs_cyc[15] != c + 8) begin
        bad++;
        $display("FAIL bp_second_full: got cycle %0d, want %0d", hs_cyc[15], c + 8);
      end
      total++;
      if (sr9 !== 1'b0 || sr10 !== 1'b1) begin
        bad++;
        $display("FAIL bp_ready: got phase7=%b next=%b, want 0 and 1", sr9, sr10);
      end
      total++;
      if (hs_cyc[16] != c + 10) begin
        bad++;
        $display("FAIL bp_resume: got cycle %0d, want %0d", hs_cyc[16], c + 10);
      end
    end
    total++;
    if (v_cnt != 40 || rises != 1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL bp_bursts: got %0d cycles %0d runs %0d unseen, want 40 1 0",
               v_cnt, rises, exp_q.size());
    end
  endtask

  task automatic test_late_frame();
    do_reset(2);
    push_frame(16'h4000, 1'b0);
    push_flush(1'b1);
    push_frame(16'h5000, 1'b0);
    push_flush(1'b1);
    feed_en = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      // Hold off frame B so its last sample lands in FLUSH phase 3.
      if (hs_cyc.size() == 8 && feed_from == 0) feed_from = hs_cyc[7] + 8;
    end
    total++;
    if (hs_cyc.size() != 16) begin
      bad++;
      $display("FAIL late_handshakes: got %0d, want 16", hs_cyc.size());
    end else begin
      total++;
      if (hs_cyc[15] != hs_cyc[7] + 15) begin
        bad++;
        $display("FAIL late_timing: got cycle %0d, want %0d", hs_cyc[15], hs_cyc[7] + 15);
      end
    end
    total++;
    if (v_cnt != 40 || rises != 1) begin
      bad++;
      $display("FAIL late_valid: got %0d cycles in %0d runs, want 40 in 1", v_cnt, rises);
    end
    total++;
    if (bin_cnt != 16) begin
      bad++;
      $display("FAIL late_bins: got %0d bin_valid cycles, want 16", bin_cnt);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL late_missing: got %0d beats unseen, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_send();
    int waited = 0;
    do_reset(2);
    push_frame(16'h6000, 1'b0);
    feed_en = 1'b1;
    while (first_rise < 0 && waited < 40) begin
      tick();
      waited++;
    end
    total++;
    if (first_rise < 0) begin
      bad++;
      $display("FAIL midrst_setup: got no burst, want one within 40 cycles");
    end
    repeat (4) tick();
    assert_reset();
    #1;
    total++;
    if (fft_valid !== 1'b0 || fft_data !== '0) begin
      bad++;
      $display("FAIL midrst_async: got v=%b d=%h, want v=0 d=0", fft_valid, fft_data);
    end
    repeat (2) tick();
    rst = 1'b0;
    push_frame(16'd100, 1'b0);
    push_flush(1'b1);
    feed_en = 1'b1;
    repeat (60) tick();
    total++;
    if (hs_cyc.size() != 8) begin
      bad++;
      $display("FAIL midrst_handshakes: got %0d, want 8", hs_cyc.size());
    end else begin
      total++;
      if (first_rise != hs_cyc[7] + 2) begin
        bad++;
        $display("FAIL midrst_latency: got rise at %0d, want %0d", first_rise, hs_cyc[7] + 2);
      end
    end
    total++;
    if (v_cnt != 20 || bin_cnt != 8 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL midrst_burst: got %0d cycles %0d bins %0d unseen, want 20 8 0",
               v_cnt, bin_cnt, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_continuous();
    test_back_pressure();
    test_late_frame();
    test_reset_mid_send();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft8_frame_loader.md
# fft8_frame_loader

Upstream framing stage for the 8-point radix-2 DIF FFT core. Accepts a ready/valid stream of 16-bit samples, double-buffers them into 8-sample frames, and replays each frame as the 10-cycle valid burst the FFT core requires: 8 samples, then 2 zero-padded compute cycles. After the last real frame it appends one zero flush frame so the core can emit the final spectrum. It also provides `bin_valid`/`bin_idx` tags that mark which cycles of the core's serial magnitude output carry real results.

## Interface
- `DATA_W`, 16, sample width; must match the FFT core input.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `s_data`  in  DATA_W  input sample.
- `s_valid`  in  1  sample present.
- `s_ready`  out  1  loader can accept a sample; a transfer occurs when `s_valid && s_ready` at a rising edge.
- `fft_valid`  out  1  drives the core's `valid` input.
- `fft_data`  out  DATA_W  drives the core's `data_in` input.
- `frame_start`  out  1  high in phase 0 of every burst (SEND or FLUSH).
- `bin_valid`  out  1  the core's current output is a real bin of the previous real frame.
- `bin_idx`  out  3  bin number of the core's current output; equals the phase.

## Operation
- **Buffer.** Two banks of 8×DATA_W, each with a `full` flag.
- **Write side.**
  - Pointers `wr_bank`/`wr_idx`. Each transfer writes `bank[wr_bank][wr_idx]` and increments `wr_idx`.
  - On the transfer with `wr_idx==7`: set `full[wr_bank]`, toggle `wr_bank`, wrap `wr_idx` to 0.
  - `s_ready = !full[wr_bank] && !rst` (combinational).
- **Read FSM.** States IDLE, SEND, FLUSH. Counter `phase` runs 0..9. Read pointer is `rd_bank`.
- **IDLE:**
  - `fft_valid` is 0.
  - If `full[rd_bank]`: go to SEND with phase 0.
- **SEND:**
  - `fft_valid` is 1.
  - Phases 0–7: `fft_data = bank[rd_bank][phase]`.
  - Phases 8–9: `fft_data = 0`.
  - At the end of phase 7: clear `full[rd_bank]` and toggle `rd_bank`.
- **End of phase 9 in SEND:**
  - If `full[rd_bank]`: go to SEND with phase 0. `fft_valid` stays high with no gap, because the core counter wraps 9→0.
  - Otherwise go to FLUSH with phase 0.
- **FLUSH:**
  - `fft_valid` is 1 and `fft_data` is 0 for all 10 phases.
  - At the end of phase 9: if `full[rd_bank]`, go to SEND; otherwise go to IDLE.
  - A bank that fills mid-flush waits for phase 9. FLUSH is never aborted.
- **Result tagging.**
  - Register `prev_real` is set at the end of phase 9 of SEND and cleared at the end of phase 9 of FLUSH.
  - `bin_valid = fft_valid && phase<=7 && prev_real`.
  - `bin_idx = phase` when `bin_valid` is high, otherwise 0.
- **Simultaneous events.** Write completing bank A while read releases bank B: both take effect at the same edge with no conflict. Both banks full: `s_ready` is 0 until the end of phase 7 of the current SEND.

## Timing
- **Reset values:**
  - `s_ready` = 0 while `rst` is high; 1 in the first cycle after release.
  - `fft_valid`, `fft_data`, `frame_start`, `bin_valid`, `bin_idx` = 0.
  - FSM in IDLE. Both `full` flags, `prev_real`, and all pointers = 0.
- **Reset mid-burst.** `fft_valid` drops asynchronously and buffered samples are discarded. The core then self-clears because its `valid` is low.
- **Registered outputs.** All outputs except `s_ready` are registered.
- **Latency.**
  - The 8th sample transfers at edge E with the loader in IDLE.
  - IDLE sees `full` in cycle E+1.
  - The first `fft_valid=1` appears in cycle E+2, i.e. two cycles after the handshake edge.
- **Throughput.** Sustained 8 samples per 10 cycles. The input is back-pressured 2 of every 10 cycles under continuous load.
- **Burst length.** Bursts are exactly 10 cycles; `fft_valid` never drops mid-burst.
- **Result alignment.** The core output for the previous frame's bin k appears combinationally during the cycle with phase==k of the following burst, so `bin_idx` aligns with that data.

## Test plan
- **Reset.** Hold `rst` high 5 cycles mid-stream → all outputs 0 and `s_ready`=0; `s_ready`=1 in the first cycle after release.
- **Single frame.** Send samples 1..8 back-to-back, then idle.
  - `fft_valid` first high 2 cycles after the 8th handshake.
  - SEND shows `fft_data` 1..8, 0, 0.
  - FLUSH follows immediately: 10 zeros, `bin_valid` high in phases 0–7 with `bin_idx` 0..7.
  - Then IDLE.
- **Continuous stream.** Hold `s_valid`=1 for 40 samples.
  - `fft_valid` continuous for 5 SEND bursts plus 1 FLUSH (60 cycles).
  - `s_ready` low exactly 2 of every 10 cycles at steady state.
  - `bin_valid` high for 8 cycles in bursts 2–6.
- **Back-pressure.** Fill both banks while the first SEND runs → `s_ready` is 0 until the end of phase 7; the next sample is accepted the cycle after.
- **Late frame during FLUSH.** Complete a frame during FLUSH phase 3 → FLUSH finishes all 10 cycles, then SEND starts with no gap. `bin_valid` stays low during that SEND's phases 0–7.
- **Reset mid-SEND.** Assert `rst` at phase 4 → `fft_valid` drops immediately. After release, 8 new samples (100..107) produce a clean burst 100..107, 0, 0.
